// File: rtl/muller_c_handshake_monitor_pkg.sv
`default_nettype none
// ============================================================================
// muller_mon_pkg : shared state encoding and default sizing for the monitor
// Rev 1.0
// ============================================================================
package muller_mon_pkg;

  typedef enum logic [1:0] {
    LOW      = 2'b00,
    ARMED_HI = 2'b01,
    HIGH     = 2'b10,
    ARMED_LO = 2'b11
  } mon_state_e;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_TIMEOUT     = 255;

endpackage : muller_mon_pkg
`default_nettype wire

// File: rtl/muller_c_handshake_monitor_if.sv
`default_nettype none
// ============================================================================
// muller_c_handshake_monitor_if : C-element request inputs and output
// Rev 1.0
// ============================================================================
interface muller_c_handshake_monitor_if;
  logic a_i;
  logic b_i;
  logic c_i;

  modport master (output a_i, output b_i, output c_i);
  modport slave  (input  a_i, input  b_i, input  c_i);
endinterface : muller_c_handshake_monitor_if
`default_nettype wire

// File: rtl/muller_c_handshake_monitor_sync.sv
`default_nettype none
// ============================================================================
// muller_sync : SYNC_STAGES-deep single-bit synchronizer, sync active-low rst
// Rev 1.0
// ============================================================================
module muller_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic d_i,
  output logic      q_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule : muller_sync
`default_nettype wire

// File: rtl/muller_c_handshake_monitor.sv
`default_nettype none
// ============================================================================
// muller_c_handshake_monitor : four-phase handshake tracker for a C-element
// Rev 1.0
// ============================================================================
module muller_c_handshake_monitor
  import muller_mon_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  wire logic                   wb_clk_i,
  input  wire logic                   rst_n,
  muller_c_handshake_monitor_if.slave hs,
  input  wire logic                   clr_i,
  output logic [CNT_W-1:0]            cycle_cnt_o,
  output logic [1:0]                  state_o,
  output logic                        viol_o,
  output logic                        stall_o,
  output logic                        cnt_wrap_o
);

  localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

  logic as, bs, cs;

  muller_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
    .clk(wb_clk_i), .rst_n(rst_n), .d_i(hs.a_i), .q_o(as));
  muller_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
    .clk(wb_clk_i), .rst_n(rst_n), .d_i(hs.b_i), .q_o(bs));
  muller_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_c (
    .clk(wb_clk_i), .rst_n(rst_n), .d_i(hs.c_i), .q_o(cs));

  mon_state_e       state_q, state_d;
  logic [7:0]       tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             viol_q, viol_d;
  logic             stall_q, stall_d;
  logic             wrap_q, wrap_d;
  logic             viol_set, incr, armed_stay;

  // Next state; simultaneous agreement+follow jumps straight past ARMED_*
  always_comb begin
    state_d  = state_q;
    viol_set = 1'b0;
    incr     = 1'b0;
    unique case (state_q)
      LOW: begin
        if (cs) begin
          state_d  = HIGH;
          viol_set = !(as && bs);
        end else if (as && bs) begin
          state_d = ARMED_HI;
        end
      end
      ARMED_HI: begin
        if (cs)                state_d = HIGH;
        else if (!(as && bs))  state_d = LOW;
      end
      HIGH: begin
        if (!cs) begin
          state_d  = LOW;
          viol_set = as || bs;
          incr     = !(as || bs);
        end else if (!(as || bs)) begin
          state_d = ARMED_LO;
        end
      end
      ARMED_LO: begin
        if (!cs) begin
          state_d = LOW;
          incr    = 1'b1;
        end else if (as || bs) begin
          state_d = HIGH;
        end
      end
      default: state_d = LOW;
    endcase
  end

  always_comb begin
    armed_stay = (state_d == state_q) &&
                 ((state_q == ARMED_HI) || (state_q == ARMED_LO));
    tmr_d = 8'd0;
    if (armed_stay) begin
      tmr_d = (tmr_q == TMO_LIM) ? tmr_q : tmr_q + 8'd1;
    end

    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (incr) cnt_d = cnt_q + CNT_W'(1);

    // Set beats clear on the sticky flags; a dropped increment cannot wrap
    viol_d  = viol_set || (viol_q && !clr_i);
    stall_d = (armed_stay && (tmr_d == TMO_LIM)) || (stall_q && !clr_i);
    wrap_d  = (incr && !clr_i && (cnt_q == '1)) || (wrap_q && !clr_i);
  end

  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      state_q <= LOW;
      tmr_q   <= 8'd0;
      cnt_q   <= '0;
      viol_q  <= 1'b0;
      stall_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      viol_q  <= viol_d;
      stall_q <= stall_d;
      wrap_q  <= wrap_d;
    end
  end

  assign cycle_cnt_o = cnt_q;
  assign state_o     = state_q;
  assign viol_o      = viol_q;
  assign stall_o     = stall_q;
  assign cnt_wrap_o  = wrap_q;

endmodule : muller_c_handshake_monitor
`default_nettype wire

// File: tb/tb_muller_c_handshake_monitor.sv
`default_nettype none
// ============================================================================
// tb_muller_c_handshake_monitor : directed vectors against hand-derived values
// Rev 1.0
// ============================================================================
module tb_muller_c_handshake_monitor;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  logic clr16;

  logic [3:0]  cnt4;
  logic [15:0] cnt16;
  logic [1:0]  st4, st16;
  logic        viol4, stall4, wrap4;
  logic        viol16, stall16, wrap16;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  muller_c_handshake_monitor_if hs ();

  muller_c_handshake_monitor #(.SYNC_STAGES(SYNC), .CNT_W(4), .TIMEOUT(255)) dut (
    .wb_clk_i(clk), .rst_n(rst_n), .hs(hs.slave), .clr_i(clr),
    .cycle_cnt_o(cnt4), .state_o(st4), .viol_o(viol4),
    .stall_o(stall4), .cnt_wrap_o(wrap4));

  muller_c_handshake_monitor dut16 (
    .wb_clk_i(clk), .rst_n(rst_n), .hs(hs.slave), .clr_i(clr16),
    .cycle_cnt_o(cnt16), .state_o(st16), .viol_o(viol16),
    .stall_o(stall16), .cnt_wrap_o(wrap16));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pins(input logic a, input logic b, input logic c);
    hs.a_i = a;
    hs.b_i = b;
    hs.c_i = c;
  endtask

  task automatic handshake();
    pins(1, 1, 0); step(5);
    pins(1, 1, 1); step(5);
    pins(0, 0, 1); step(5);
    pins(0, 0, 0); step(5);
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    clr16 = 1'b0;
    pins(0, 0, 0);
    step(3);
    check("rst_state", 32'(st4), 32'h0);
    check("rst_cnt", 32'(cnt4), 32'h0);
    check("rst_viol", 32'(viol4), 32'h0);
    check("rst_stall", 32'(stall4), 32'h0);
    check("rst_wrap", 32'(wrap4), 32'h0);
    rst_n = 1'b1;
    step(2);

    // Legal handshake walks 00,01,10,11,00
    pins(1, 1, 0); step(SYNC);
    check("legal_pre_armed", 32'(st4), 32'h0);
    step(1);
    check("legal_armed_hi", 32'(st4), 32'h1);
    step(7);
    pins(1, 1, 1); step(SYNC + 1);
    check("legal_high", 32'(st4), 32'h2);
    step(7);
    pins(0, 0, 1); step(SYNC + 1);
    check("legal_armed_lo", 32'(st4), 32'h3);
    step(7);
    pins(0, 0, 0); step(SYNC + 1);
    check("legal_low", 32'(st4), 32'h0);
    check("legal_cnt", 32'(cnt4), 32'h1);
    check("legal_viol", 32'(viol4), 32'h0);
    step(7);

    // Output moves without agreement
    pins(1, 0, 0); step(10);
    pins(1, 0, 1); step(SYNC);
    check("viol_early", 32'(viol4), 32'h0);
    step(1);
    check("viol_set", 32'(viol4), 32'h1);
    check("viol_state", 32'(st4), 32'h2);
    step(5);
    clr = 1'b1; step(1); clr = 1'b0;
    check("viol_clr", 32'(viol4), 32'h0);
    check("viol_clr_cnt", 32'(cnt4), 32'h0);
    pins(0, 0, 1); step(10);
    pins(0, 0, 0); step(10);
    check("viol_recover_cnt", 32'(cnt4), 32'h1);
    check("viol_recover_flag", 32'(viol4), 32'h0);
    clr = 1'b1; step(1); clr = 1'b0;

    // Stall: inputs agree, output never follows
    pins(1, 1, 0); step(SYNC + 1);
    check("stall_armed", 32'(st4), 32'h1);
    step(254);
    check("stall_early", 32'(stall4), 32'h0);
    step(1);
    check("stall_set", 32'(stall4), 32'h1);
    check("stall_state", 32'(st4), 32'h1);
    step(45);
    check("stall_hold_state", 32'(st4), 32'h1);
    check("stall_hold_flag", 32'(stall4), 32'h1);
    pins(1, 1, 1); step(10);
    pins(0, 0, 1); step(10);
    pins(0, 0, 0); step(10);
    check("stall_done_cnt", 32'(cnt4), 32'h1);
    clr = 1'b1; step(1); clr = 1'b0;
    check("stall_clr", 32'(stall4), 32'h0);
    check("stall_clr_cnt", 32'(cnt4), 32'h0);

    // Wrap of the 4-bit counter
    for (int i = 0; i < 16; i++) begin
      handshake();
      if (i == 14) begin
        check("wrap_cnt15", 32'(cnt4), 32'hF);
        check("wrap_before", 32'(wrap4), 32'h0);
      end
    end
    check("wrap_cnt0", 32'(cnt4), 32'h0);
    check("wrap_flag", 32'(wrap4), 32'h1);
    check("wide_cnt19", 32'(cnt16), 32'd19);
    check("wide_wrap", 32'(wrap16), 32'h0);
    pins(1, 1, 0); step(5);
    pins(1, 1, 1); step(5);
    pins(0, 0, 1); step(5);
    pins(0, 0, 0); step(SYNC);
    clr = 1'b1; step(1); clr = 1'b0;
    check("clr_vs_incr_cnt", 32'(cnt4), 32'h0);
    check("clr_vs_incr_wrap", 32'(wrap4), 32'h0);
    check("clr_vs_incr_state", 32'(st4), 32'h0);
    check("wide_cnt20", 32'(cnt16), 32'd20);
    step(5);

    // Simultaneous edges, then reset mid-handshake with pins high
    pins(1, 1, 1); step(SYNC);
    check("simul_pre", 32'(st4), 32'h0);
    step(1);
    check("simul_high", 32'(st4), 32'h2);
    check("simul_viol", 32'(viol4), 32'h0);
    step(5);
    rst_n = 1'b0; step(1);
    check("mrst_state", 32'(st4), 32'h0);
    check("mrst_wide_cnt", 32'(cnt16), 32'h0);
    rst_n = 1'b1;
    step(SYNC);
    check("mrst_pre", 32'(st4), 32'h0);
    step(1);
    check("mrst_high", 32'(st4), 32'h2);
    check("mrst_viol", 32'(viol4), 32'h0);
    check("mrst_wide_state", 32'(st16), 32'h2);
    pins(0, 0, 0); step(SYNC + 1);
    check("simul_fall_state", 32'(st4), 32'h0);
    check("simul_fall_cnt", 32'(cnt4), 32'h1);
    check("simul_fall_viol", 32'(viol4), 32'h0);
    check("wide_stall", 32'(stall16), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_muller_c_handshake_monitor
`default_nettype wire

// File: doc/muller_c_handshake_monitor.md
Name: muller_c_handshake_monitor

Overview:
- Clocked observer sitting directly downstream of the Muller C-element core; it consumes the C-element's two request inputs and its output.
- Synchronizes the three asynchronous signals into the clock domain and tracks four-phase handshake progress.
- Counts completed handshake cycles and flags protocol violations (output moved without input agreement) and stalls (inputs agree, output never follows).
- Results drive the user-project status outputs for bring-up and formal cover correlation.

Parameters:
- SYNC_STAGES, 2, flop depth of each input synchronizer; legal values 2..4.
- CNT_W, 16, width of the completed-cycle counter.
- TIMEOUT, 255, cycles the inputs may agree before a non-following output raises stall; must fit 8 bits.

Ports:
- wb_clk_i, input, 1, block clock.
- rst_n, input, 1, synchronous active-low reset.
- a_i, input, 1, C-element input A; asynchronous.
- b_i, input, 1, C-element input B; asynchronous.
- c_i, input, 1, C-element output; asynchronous.
- clr_i, input, 1, synchronous clear of the counter and sticky flags; the state machine is unaffected.
- cycle_cnt_o, output, CNT_W, number of completed rise+fall handshakes.
- state_o, output, 2, current FSM state encoding.
- viol_o, output, 1, sticky protocol-violation flag.
- stall_o, output, 1, sticky timeout flag.
- cnt_wrap_o, output, 1, sticky counter-overflow flag.

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset is synchronous, active-low on rst_n, sampled on the rising edge.
- Values in reset:
  - All synchronizer flops 0.
  - state = LOW (2'b00).
  - cycle_cnt_o = 0; viol_o = stall_o = cnt_wrap_o = 0.
  - Timeout counter = 0.
- Synchronization: a_i, b_i and c_i each pass through an independent SYNC_STAGES flop chain. as, bs, cs denote the last stage.
  - Latency from an input edge to its first visible effect is SYNC_STAGES+1 cycles: SYNC_STAGES to sync, plus one for the state register.
- FSM states:
  - LOW=00: cs=0, inputs not both 1.
  - ARMED_HI=01: as&bs=1, cs still 0.
  - HIGH=10: cs=1, inputs not both 0.
  - ARMED_LO=11: as|bs=0, cs still 1.
- Transitions, each evaluated on the synchronized values every cycle:
  - LOW -> ARMED_HI when as&bs.
  - LOW -> HIGH with viol set when cs=1 and !(as&bs).
  - ARMED_HI -> HIGH when cs=1.
  - ARMED_HI -> LOW when inputs withdraw before cs rises. This is not a violation; the C-element is allowed to hold.
  - HIGH -> ARMED_LO when !(as|bs).
  - HIGH -> LOW with viol set when cs=0 and (as|bs).
  - ARMED_LO -> LOW when cs=0. This increments the cycle counter.
  - ARMED_LO -> HIGH when inputs re-assert before cs falls.
- Simultaneous events: when inputs agree and cs follows in the same sampled cycle, take the legal transition directly, skipping the ARMED state.
  - LOW with as&bs&cs -> HIGH, no violation.
  - HIGH with !as&!bs&!cs -> LOW, count increments.
- Timeout counter:
  - Runs only in ARMED_HI or ARMED_LO and clears on any state change.
  - On reaching TIMEOUT it sets stall_o and saturates. The FSM stays where it is.
- Cycle counter:
  - Wraps from 2^CNT_W-1 to 0 and sets cnt_wrap_o on that cycle.
  - If clr_i and an increment land in the same cycle, clr wins: the counter goes to 0 and the increment is dropped.
- Sticky flags: cleared only by rst_n or clr_i.
  - If clr_i and a new set event land in the same cycle, set wins and the flag reads 1 next cycle.
- Reset mid-handshake: the FSM returns to LOW regardless of the pins.
  - If the pins are then at a=b=c=1, the FSM proceeds LOW -> HIGH with no violation, via the simultaneous rule, after SYNC_STAGES+1 cycles.
- Outputs are all registered; there is no combinational path from any input to any output.

Decomposition:
- Package muller_mon_pkg holds:
  - the state typedef (LOW, ARMED_HI, HIGH, ARMED_LO with the encodings above);
  - the default constants for SYNC_STAGES, CNT_W and TIMEOUT.
- One sub-module, muller_sync: a parameterized SYNC_STAGES-deep single-bit synchronizer with synchronous active-low reset. It is instantiated three times.
- The FSM, timeout counter, cycle counter and flags stay in the top module.

Test Plan:
- Legal handshakes: reset, then drive a=1, b=1, then c=1; then a=0, b=0, then c=0, with 10 cycles between each change. Expect cycle_cnt_o=1, viol_o=0, and state_o passing 00,01,10,11,00.
- Output without agreement: a=1, b=0, c=1. Expect viol_o=1 exactly SYNC_STAGES+1 cycles after the c edge and state_o=10. A following clr_i pulse gives viol_o=0.
- Stall: a=b=1, c held at 0 for 300 cycles. Expect stall_o=1 at TIMEOUT cycles after state_o=01 is reached, and the state remains 01.
- Counter wrap: CNT_W=4, 16 legal handshakes. Expect cycle_cnt_o=0 and cnt_wrap_o=1; clr_i together with the 17th completion gives cycle_cnt_o=0.
- Simultaneous edges and mid-run reset: a, b and c all rise in the same clock. Expect LOW->HIGH with viol_o=0. Then assert rst_n=0 for 1 cycle with pins held high. Expect state_o=00 during reset, then 10 after SYNC_STAGES+1 cycles, and viol_o=0.
